// File: rtl/twos_to_signmag.sv
// Bit-serial two's-complement to sign-magnitude converter with valid/ready handshakes.
// The magnitude is built LSB first using the copy-to-first-one-then-invert rule.
module twos_to_signmag #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [WIDTH-1:0] mag,
    output logic             ovfl
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic             sign_r_q, sign_r_d;
    logic             sign_q, sign_d;
    logic             ovfl_q, ovfl_d;
    logic             out_valid_q, out_valid_d;
    logic             out_bit;
    logic             last_bit;
    logic [WIDTH-1:0] acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            opnd_q      <= '0;
            acc_q       <= '0;
            mag_q       <= '0;
            cnt_q       <= '0;
            seen_q      <= 1'b0;
            sign_r_q    <= 1'b0;
            sign_q      <= 1'b0;
            ovfl_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            sign_r_q    <= sign_r_d;
            sign_q      <= sign_d;
            ovfl_q      <= ovfl_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StShift;
            StShift: if (last_bit) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        sign_r_d    = sign_r_q;
        sign_d      = sign_q;
        ovfl_d      = ovfl_q;
        out_valid_d = out_valid_q;
        // Negative: bits up to and including the first one pass through, the rest invert.
        out_bit     = (sign_r_q && seen_q) ? ~opnd_q[0] : opnd_q[0];
        acc_next    = {out_bit, acc_q};
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    opnd_d   = a;
                    sign_r_d = a[WIDTH-1];
                    seen_d   = 1'b0;
                    cnt_d    = '0;
                end
            end
            StShift: begin
                opnd_d = {1'b0, opnd_q[WIDTH-1:1]};
                acc_d  = acc_next[WIDTH-1:1];
                seen_d = seen_q | opnd_q[0];
                cnt_d  = cnt_q + CntW'(1);
                if (last_bit) begin
                    mag_d       = acc_next;
                    sign_d      = sign_r_q;
                    ovfl_d      = sign_r_q & out_bit;
                    out_valid_d = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = out_valid_q;
        sign      = sign_q;
        mag       = mag_q;
        ovfl      = ovfl_q;
    end

endmodule

// File: tb/tb_twos_to_signmag.sv
// Directed and sweep bench for twos_to_signmag (WIDTH=8).
module tb_twos_to_signmag;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic       out_valid;
    logic       out_ready;
    logic       sign;
    logic [7:0] mag;
    logic       ovfl;

    int n_checks = 0;
    int n_fail   = 0;

    twos_to_signmag #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .mag       (mag),
        .ovfl      (ovfl)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operand from IDLE, returns the result and the accept-to-valid latency.
    task automatic run_op(input logic [7:0] val, input int stall, output logic s,
                          output logic [7:0] m, output logic o, output int lat);
        in_valid = 1'b1;
        a        = val;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
        s = sign;
        m = mag;
        o = ovfl;
        for (int i = 0; i < stall; i++) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
        end
        n_checks++;
        if (sign !== 1'b0 || mag !== 8'h00 || ovfl !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out got sign=%b mag=%h ovfl=%b exp 0 00 0", sign, mag, ovfl);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] vin  [6] = '{8'h05, 8'hFB, 8'hFF, 8'h81, 8'h80, 8'h00};
        logic [7:0] vmag [6] = '{8'h05, 8'h05, 8'h01, 8'h7F, 8'h80, 8'h00};
        logic       vsgn [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       vovf [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       s, o;
        logic [7:0] m;
        int         lat;
        for (int i = 0; i < 6; i++) begin
            run_op(vin[i], 0, s, m, o, lat);
            n_checks++;
            if (lat !== 8) begin
                n_fail++;
                $display("FAIL vec_latency a=%h got %0d exp 8", vin[i], lat);
            end
            n_checks++;
            if (s !== vsgn[i] || m !== vmag[i] || o !== vovf[i]) begin
                n_fail++;
                $display("FAIL vec_result a=%h got sign=%b mag=%h ovfl=%b exp %b %h %b",
                         vin[i], s, m, o, vsgn[i], vmag[i], vovf[i]);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic       s, o;
        logic [7:0] m;
        int         lat;
        in_valid = 1'b1;
        a        = 8'hCD;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL bp_latency got %0d exp 8", lat);
        end
        // 0xCD -> magnitude 0x33
        in_valid = 1'b1;
        a        = 8'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || mag !== 8'h33 || sign !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b mag=%h sign=%b exp 1 0 33 1",
                         i, out_valid, in_ready, mag, sign);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || mag !== 8'h33) begin
            n_fail++;
            $display("FAIL bp_release got ov=%b ir=%b mag=%h exp 0 1 33", out_valid, in_ready, mag);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_capture got ir=%b ov=%b exp 1 0", in_ready, out_valid);
        end
        run_op(8'h10, 0, s, m, o, lat);
        n_checks++;
        if (m !== 8'h10 || s !== 1'b0 || o !== 1'b0 || lat !== 8) begin
            n_fail++;
            $display("FAIL bp_second got mag=%h sign=%b ovfl=%b lat=%0d exp 10 0 0 8",
                     m, s, o, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic       s, o;
        logic [7:0] m;
        int         lat;
        int         seen_valid;
        // Leave a nonzero negative result on the outputs first.
        run_op(8'hFB, 0, s, m, o, lat);
        in_valid = 1'b1;
        a        = 8'hF0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_hs got ir=%b ov=%b exp 1 0", in_ready, out_valid);
        end
        n_checks++;
        if (mag !== 8'h00 || sign !== 1'b0 || ovfl !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_out got mag=%h sign=%b ovfl=%b exp 00 0 0", mag, sign, ovfl);
        end
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen_valid++;
        end
        n_checks++;
        if (seen_valid !== 0) begin
            n_fail++;
            $display("FAIL midrst_no_result got %0d valid cycles exp 0", seen_valid);
        end
    endtask

    task automatic test_sweep();
        logic       s, o;
        logic [7:0] m;
        logic [7:0] v;
        logic [7:0] exp_mag;
        int         lat;
        for (int i = 0; i < 256; i++) begin
            v       = 8'(i);
            exp_mag = v[7] ? 8'(~v + 8'd1) : v;
            run_op(v, int'($urandom_range(0, 3)), s, m, o, lat);
            n_checks++;
            if (m !== exp_mag || s !== v[7] || o !== (v == 8'h80) || lat !== 8) begin
                n_fail++;
                $display("FAIL sweep a=%h got mag=%h sign=%b ovfl=%b lat=%0d exp %h %b %b 8",
                         v, m, s, o, lat, exp_mag, v[7], (v == 8'h80));
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_pressure();
        test_reset_mid();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/twos_to_signmag.md
Name: twos_to_signmag

Overview:
- Sequential inverse of the team's combinational sign changer. It takes a WIDTH-bit two's-complement value and returns it as sign plus unsigned magnitude.
- The magnitude is built bit-serially, LSB first, using the copy-to-first-one-then-invert rule. No parallel adder is used.
- Sits between arithmetic datapaths and sign-magnitude consumers such as displays and serial formatters.
- Valid/ready handshake on both sides. Latency is fixed regardless of the operand value.

Parameters:
- WIDTH, 8, operand and magnitude width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand a is valid.
- in_ready  output  1  block can accept an operand.
- a  input  WIDTH  two's-complement operand.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sign  output  1  1 = operand was negative.
- mag  output  WIDTH  unsigned magnitude |a|.
- ovfl  output  1  active-high; |a| does not fit in WIDTH-1 bits, i.e. a = -2^(WIDTH-1).

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - sign=0, mag=0, ovfl=0.
  - Shift register, bit counter and seen-one flag cleared.
- in_ready = (state==IDLE), decoded from the state register.
- All other outputs are registered.
- IDLE:
  - On in_valid && in_ready, capture a into the shift register.
  - Latch sign_r = a[WIDTH-1], clear seen_one, clear cnt, go to SHIFT.
  - in_valid while not in IDLE is ignored; the operand is not captured.
- SHIFT, one bit per clock, LSB first. Let b = current LSB of the shift register.
  - If sign_r=0: out bit = b.
  - If sign_r=1: out bit = seen_one ? ~b : b; then seen_one |= b.
  - The out bit shifts into the MSB of the magnitude register; the operand register shifts right.
  - cnt increments. When cnt == WIDTH-1 (last bit), next state is DONE.
  - On that same edge: load mag, set sign = sign_r, set ovfl, set out_valid=1.
- ovfl = sign_r && (magnitude == 2^(WIDTH-1)): the MSB of the result is set while sign_r is set.
- Latency: operand accepted at edge E0; out_valid is high after edge E_WIDTH, i.e. WIDTH cycles, for every operand.
- DONE:
  - out_valid held high; sign, mag and ovfl stable until out_ready.
  - On out_valid && out_ready: out_valid=0, go to IDLE.
  - No new operand is accepted on that same edge.
  - Throughput: one result per WIDTH+2 cycles with out_ready tied high.
- After handshake: sign, mag and ovfl keep their last values until the next result loads. Only out_valid qualifies them.
- Zero operand: sign=0, mag=0, ovfl=0.
- Most-negative operand: sign=1, mag=2^(WIDTH-1), ovfl=1. The magnitude is still exact in WIDTH bits.
- Reset mid-SHIFT or mid-DONE:
  - Operand is discarded and all outputs return to reset values on that edge.
  - No out_valid pulse is produced afterwards.
- out_ready while out_valid=0 has no effect.

Test Plan:
- a=0x05, in_valid 1 cycle, out_ready=1 -> out_valid exactly 8 cycles after accept; sign=0, mag=0x05, ovfl=0.
- a=0xFB -> sign=1, mag=0x05, ovfl=0. Also a=0xFF -> sign=1, mag=0x01; a=0x81 -> sign=1, mag=0x7F.
- a=0x80 -> sign=1, mag=0x80, ovfl=1. Also a=0x00 -> sign=0, mag=0x00, ovfl=0, with the same 8-cycle latency.
- Back-pressure: out_ready=0 for 5 cycles after out_valid.
  - Required: out_valid, sign and mag held constant, in_ready=0.
  - Second operand 0x10 driven during the stall is not captured.
  - After out_ready=1 and a return to IDLE, 0x10 presented again gives mag=0x10.
- Reset: apply rst=1 for 1 cycle after 3 SHIFT cycles of a=0xF0.
  - Required next cycle: in_ready=1, out_valid=0, mag=0, sign=0, ovfl=0.
  - No result is ever emitted for 0xF0.
- Randomized sweep of all 256 operands with random out_ready stalls -> mag == |a|, sign == a[7], ovfl only for 0x80, latency always 8.
